// File: rtl/mhsa_pkg.sv
// mhsa_pkg: shared types and helpers for the mhsa_acc_top datapath stages.
//   scale_state_e   : FSM states of scale_unit
//   LANE_W_DEF      : default signed score lane width
//   SCALE_SHIFT_MIN/MAX : legal range of the scale_unit right shift
//   sat_lane()      : clamp a signed value to a w-bit signed range
package mhsa_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCalc,
      StWrite,
      StDone
   } scale_state_e;

   localparam int unsigned LANE_W_DEF      = 8;
   localparam int unsigned SCALE_SHIFT_MIN = 1;
   localparam int unsigned SCALE_SHIFT_MAX = 15;

   // Clamp v to [-2^(w-1), 2^(w-1)-1]; w must be 2..31.
   function automatic logic signed [31:0] sat_lane(input logic signed [31:0] v,
                                                   input int unsigned       w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) begin
         sat_lane = hi;
      end else if (v < lo) begin
         sat_lane = lo;
      end else begin
         sat_lane = v;
      end
   endfunction

endpackage

// File: rtl/scale_unit_lane.sv
// scale_lane: one signed score lane, combinational multiply / shift / saturate.
//   lane   in  LANE_W  signed input score
//   scaled out LANE_W  saturated (lane * SCALE_MUL) >>> SCALE_SHIFT
// Build option: SCALE_ROUND_EN adds 2^(SCALE_SHIFT-1) before the shift (round half up);
// without it the shift truncates toward -inf.
module scale_lane
   import mhsa_pkg::*;
#(
   parameter int unsigned LANE_W      = LANE_W_DEF,
   parameter int unsigned SCALE_MUL   = 1,
   parameter int unsigned SCALE_SHIFT = 3
) (
   input  logic [LANE_W-1:0] lane,
   output logic [LANE_W-1:0] scaled
);

   // LANE_W+9 holds the full product; one extra bit keeps the rounding add from overflowing.
   // The saturation helper works on 32 bits, so LANE_W is limited to 22.
   localparam int unsigned PW = LANE_W + 10;

   logic signed [PW-1:0] lane_s;
   logic signed [PW-1:0] mul_s;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;

   assign lane_s = PW'($signed(lane));
   assign mul_s  = PW'($signed({1'b0, 8'(SCALE_MUL)}));
   assign prod   = lane_s * mul_s;

`ifdef SCALE_ROUND_EN
   localparam logic signed [PW-1:0] RoundHalf = PW'(1) << (SCALE_SHIFT - 1);
   assign shifted = (prod + RoundHalf) >>> SCALE_SHIFT;
`else
   assign shifted = prod >>> SCALE_SHIFT;
`endif

   assign scaled = LANE_W'(sat_lane(32'(shifted), LANE_W));

endmodule

// File: rtl/scale_unit.sv
// scale_unit: in-place score scaling over NUM_WORDS packed words of one SRAM bar.
// Each word is read, every signed lane is scaled by scale_lane, and the word is written back.
// Three cycles per word (READ, CALC, WRITE); start rise to done = 3*NUM_WORDS+1 cycles.
//   clk, rst      clock, synchronous active-high reset
//   start         level request, held high for the whole run
//   done          high while in DONE
//   write_en_bar  bar write strobe
//   data_in_bar   bar write data (WIDTH)
//   addr_bar      bar address (32)
//   data_out_bar  bar read data, valid one cycle after addr_bar (WIDTH)
// Build option: SCALE_ROUND_EN selects round-half-up in scale_lane; timing is unchanged.
module scale_unit
   import mhsa_pkg::*;
#(
   parameter int unsigned WIDTH       = 64,
   parameter int unsigned LANE_W      = LANE_W_DEF,
   parameter int unsigned NUM_WORDS   = 512,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned SCALE_MUL   = 1,
   parameter int unsigned SCALE_SHIFT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             done,
   output logic             write_en_bar,
   output logic [WIDTH-1:0] data_in_bar,
   output logic [31:0]      addr_bar,
   input  logic [WIDTH-1:0] data_out_bar
);

   localparam int unsigned LANES = WIDTH / LANE_W;
   localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
   localparam logic [CNT_W-1:0] LastWord = CNT_W'(NUM_WORDS - 1);

   if (SCALE_SHIFT < SCALE_SHIFT_MIN || SCALE_SHIFT > SCALE_SHIFT_MAX) begin : g_bad_shift
      $error("scale_unit: SCALE_SHIFT out of range");
   end
   if (WIDTH % LANE_W != 0) begin : g_bad_width
      $error("scale_unit: WIDTH must be a multiple of LANE_W");
   end

   scale_state_e     state_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [WIDTH-1:0] result_q;
   logic             done_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [WIDTH-1:0] scaled_word;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      scale_lane #(
         .LANE_W      (LANE_W),
         .SCALE_MUL   (SCALE_MUL),
         .SCALE_SHIFT (SCALE_SHIFT)
      ) u_lane (
         .lane   (data_out_bar[i*LANE_W +: LANE_W]),
         .scaled (scaled_word[i*LANE_W +: LANE_W])
      );
   end

   // Outputs are registered alongside the state, so each register is loaded with the
   // value belonging to the state being entered. Anything not set below returns to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         word_cnt_q <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
      end else begin
         done_q <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StRead;
                  word_cnt_q <= '0;
                  addr_q     <= 32'(BASE_ADDR);
               end
            end
            StRead: begin
               state_q <= start ? StCalc : StIdle;
            end
            StCalc: begin
               if (!start) begin
                  state_q <= StIdle;
               end else begin
                  state_q  <= StWrite;
                  result_q <= scaled_word;
                  we_q     <= 1'b1;
                  addr_q   <= 32'(BASE_ADDR) + 32'(word_cnt_q);
               end
            end
            StWrite: begin
               if (!start) begin
                  state_q <= StIdle;
               end else if (word_cnt_q == LastWord) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= StRead;
                  word_cnt_q <= word_cnt_q + 1'b1;
                  addr_q     <= 32'(BASE_ADDR) + 32'(word_cnt_q) + 32'd1;
               end
            end
            StDone: begin
               // No rerun while start stays high; a fresh rise is needed.
               if (!start) begin
                  state_q <= StIdle;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // rst masks the outputs immediately so a write already on the bar is dropped that cycle.
   assign done         = done_q & ~rst;
   assign write_en_bar = we_q & ~rst;
   assign addr_bar     = rst ? '0 : addr_q;
   assign data_in_bar  = (we_q && !rst) ? result_q : '0;

endmodule

// File: tb/tb_scale_unit.sv
module tb_scale_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SCALE_ROUND_EN
   localparam logic [63:0] EXP_NEG1 = 64'h0000_0000_0000_0000;
   localparam logic [63:0] EXP_MIX  = 64'h7F80_2D00_A65B_D32D;
`else
   localparam logic [63:0] EXP_NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] EXP_MIX  = 64'h7F80_2D00_A55A_D22D;
`endif

   // DUT 1: default parameters, bar words 0..511
   logic        rst1 = 1'b1, start1 = 1'b0, done1, we1;
   logic [63:0] din1, dout1;
   logic [31:0] addr1;
   logic [63:0] mem1 [0:1023];
   logic        ld1 = 1'b0;
   logic [9:0]  ld_a1 = '0;
   logic [63:0] ld_d1 = '0;
   int          wr_cnt1 = 0, oob1 = 0;

   // DUT 2: 4 words at 0x100, MUL=181, SHIFT=2
   logic        rst2 = 1'b1, start2 = 1'b0, done2, we2;
   logic [63:0] din2, dout2;
   logic [31:0] addr2;
   logic [63:0] mem2 [0:511];
   logic        ld2 = 1'b0;
   logic [8:0]  ld_a2 = '0;
   logic [63:0] ld_d2 = '0;
   int          wr_cnt2 = 0, oob2 = 0;

   scale_unit u_dut1 (
      .clk          (clk),
      .rst          (rst1),
      .start        (start1),
      .done         (done1),
      .write_en_bar (we1),
      .data_in_bar  (din1),
      .addr_bar     (addr1),
      .data_out_bar (dout1)
   );

   scale_unit #(
      .NUM_WORDS   (4),
      .BASE_ADDR   (32'h100),
      .SCALE_MUL   (181),
      .SCALE_SHIFT (2)
   ) u_dut2 (
      .clk          (clk),
      .rst          (rst2),
      .start        (start2),
      .done         (done2),
      .write_en_bar (we2),
      .data_in_bar  (din2),
      .addr_bar     (addr2),
      .data_out_bar (dout2)
   );

   always @(posedge clk) begin
      if (ld1) begin
         mem1[ld_a1] = ld_d1;
      end else if (we1) begin
         mem1[addr1[9:0]] = din1;
         wr_cnt1 = wr_cnt1 + 1;
         if (addr1 >= 32'd512) oob1 = oob1 + 1;
      end
      dout1 <= mem1[addr1[9:0]];
   end

   always @(posedge clk) begin
      if (ld2) begin
         mem2[ld_a2] = ld_d2;
      end else if (we2) begin
         mem2[addr2[8:0]] = din2;
         wr_cnt2 = wr_cnt2 + 1;
         if (addr2 < 32'h100 || addr2 > 32'h103) oob2 = oob2 + 1;
      end
      dout2 <= mem2[addr2[8:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load1(input int a, input logic [63:0] d);
      ld1 = 1'b1; ld_a1 = 10'(a); ld_d1 = d;
      tick();
      ld1 = 1'b0;
   endtask

   task automatic load2(input int a, input logic [63:0] d);
      ld2 = 1'b1; ld_a2 = 9'(a); ld_d2 = d;
      tick();
      ld2 = 1'b0;
   endtask

   task automatic run1(output int cyc);
      start1 = 1'b1;
      cyc = 0;
      while (cyc < 4000 && done1 !== 1'b1) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run2(output int cyc);
      start2 = 1'b1;
      cyc = 0;
      while (cyc < 100 && done2 !== 1'b1) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst2 = 1'b1;
      tick(); tick();
      n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done1); end
      n_checks++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we1); end
      n_checks++; if (addr1 !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr1); end
      n_checks++; if (din1 !== 64'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", din1); end
      n_checks++; if (addr2 !== 32'h0) begin n_fail++; $display("FAIL reset_addr2 got %h want 0", addr2); end
      rst1 = 1'b0; rst2 = 1'b0;
      tick();
      n_checks++; if (we1 !== 1'b0 || addr1 !== 32'h0) begin
         n_fail++; $display("FAIL idle_outputs got we=%b addr=%h want 0/0", we1, addr1);
      end
   endtask

   task automatic test_full_run();
      int cyc, w0, bad;
      for (int i = 0; i < 1024; i++) load1(i, (i < 512) ? 64'h4040_4040_4040_4040 : 64'hDEAD_BEEF_0000_0000);
      w0 = wr_cnt1;
      run1(cyc);
      n_checks++; if (cyc !== 1537) begin n_fail++; $display("FAIL full_done_cycle got %0d want 1537", cyc); end
      n_checks++; if (wr_cnt1 - w0 !== 512) begin n_fail++; $display("FAIL full_writes got %0d want 512", wr_cnt1 - w0); end
      n_checks++; if (oob1 !== 0) begin n_fail++; $display("FAIL full_oob got %0d want 0", oob1); end
      bad = 0;
      for (int i = 0; i < 512; i++) if (mem1[i] !== 64'h0808_0808_0808_0808) bad++;
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_words got %0d bad want 0", bad); end
      n_checks++; if (mem1[512] !== 64'hDEAD_BEEF_0000_0000) begin
         n_fail++; $display("FAIL full_past_end got %h want deadbeef00000000", mem1[512]);
      end
      for (int i = 0; i < 6; i++) tick();
      n_checks++; if (done1 !== 1'b1 || wr_cnt1 - w0 !== 512) begin
         n_fail++; $display("FAIL done_hold got done=%b writes=%0d want 1/512", done1, wr_cnt1 - w0);
      end
      start1 = 1'b0;
      tick();
      n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL done_clear got %b want 0", done1); end
   endtask

   task automatic test_neg_one();
      int cyc;
      for (int i = 0; i < 512; i++) load1(i, 64'hFFFF_FFFF_FFFF_FFFF);
      run1(cyc);
      n_checks++; if (cyc !== 1537) begin n_fail++; $display("FAIL neg1_done_cycle got %0d want 1537", cyc); end
      n_checks++; if (mem1[0] !== EXP_NEG1) begin n_fail++; $display("FAIL neg1_word0 got %h want %h", mem1[0], EXP_NEG1); end
      n_checks++; if (mem1[511] !== EXP_NEG1) begin n_fail++; $display("FAIL neg1_word511 got %h want %h", mem1[511], EXP_NEG1); end
      start1 = 1'b0;
      tick();
   endtask

   task automatic test_sat_window();
      int cyc, w0;
      load2(32'hFF,  64'hAAAA_5555_AAAA_5555);
      load2(32'h100, 64'h7F80_0100_FE02_FF01);
      load2(32'h101, 64'h0101_0101_0101_0101);
      load2(32'h102, 64'h0000_0000_0000_0000);
      load2(32'h103, 64'h7F7F_7F7F_7F7F_7F7F);
      load2(32'h104, 64'h1234_5678_9ABC_DEF0);
      w0 = wr_cnt2;
      run2(cyc);
      n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL win_done_cycle got %0d want 13", cyc); end
      n_checks++; if (wr_cnt2 - w0 !== 4) begin n_fail++; $display("FAIL win_writes got %0d want 4", wr_cnt2 - w0); end
      n_checks++; if (oob2 !== 0) begin n_fail++; $display("FAIL win_oob got %0d want 0", oob2); end
      n_checks++; if (mem2[9'h100] !== EXP_MIX) begin n_fail++; $display("FAIL sat_mix got %h want %h", mem2[9'h100], EXP_MIX); end
      n_checks++; if (mem2[9'h101] !== 64'h2D2D_2D2D_2D2D_2D2D) begin
         n_fail++; $display("FAIL scale_one got %h want 2d2d2d2d2d2d2d2d", mem2[9'h101]);
      end
      n_checks++; if (mem2[9'h102] !== 64'h0) begin n_fail++; $display("FAIL scale_zero got %h want 0", mem2[9'h102]); end
      n_checks++; if (mem2[9'h103] !== 64'h7F7F_7F7F_7F7F_7F7F) begin
         n_fail++; $display("FAIL sat_pos got %h want 7f7f7f7f7f7f7f7f", mem2[9'h103]);
      end
      n_checks++; if (mem2[9'hFF] !== 64'hAAAA_5555_AAAA_5555) begin
         n_fail++; $display("FAIL below_base got %h want aaaa5555aaaa5555", mem2[9'hFF]);
      end
      n_checks++; if (mem2[9'h104] !== 64'h1234_5678_9ABC_DEF0) begin
         n_fail++; $display("FAIL above_end got %h want 123456789abcdef0", mem2[9'h104]);
      end
      start2 = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      int w0;
      logic saw_done;
      for (int i = 0; i < 4; i++) load1(i, 64'h4040_4040_4040_4040);
      w0 = wr_cnt1;
      start1 = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      n_checks++; if (addr1 !== 32'd2 || we1 !== 1'b0) begin
         n_fail++; $display("FAIL abort_read2 got addr=%h we=%b want 2/0", addr1, we1);
      end
      tick();
      n_checks++; if (addr1 !== 32'd0 || we1 !== 1'b0) begin
         n_fail++; $display("FAIL abort_calc2 got addr=%h we=%b want 0/0", addr1, we1);
      end
      start1 = 1'b0;
      tick();
      n_checks++; if (addr1 !== 32'd0 || we1 !== 1'b0 || done1 !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle got addr=%h we=%b done=%b want 0/0/0", addr1, we1, done1);
      end
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done1 === 1'b1) saw_done = 1'b1;
      end
      n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b want 0", saw_done); end
      n_checks++; if (wr_cnt1 - w0 !== 2) begin n_fail++; $display("FAIL abort_writes got %0d want 2", wr_cnt1 - w0); end
      n_checks++; if (mem1[1] !== 64'h0808_0808_0808_0808) begin
         n_fail++; $display("FAIL abort_word1 got %h want 0808080808080808", mem1[1]);
      end
      n_checks++; if (mem1[2] !== 64'h4040_4040_4040_4040) begin
         n_fail++; $display("FAIL abort_word2 got %h want 4040404040404040", mem1[2]);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, w0;
      load1(0, 64'h4040_4040_4040_4040);
      for (int i = 1; i < 512; i++) load1(i, 64'h2020_2020_2020_2020);
      w0 = wr_cnt1;
      start1 = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      n_checks++; if (we1 !== 1'b1 || addr1 !== 32'd1) begin
         n_fail++; $display("FAIL rst_write1_pos got we=%b addr=%h want 1/1", we1, addr1);
      end
      rst1 = 1'b1;
      #1;
      n_checks++; if (we1 !== 1'b0 || addr1 !== 32'h0 || din1 !== 64'h0 || done1 !== 1'b0) begin
         n_fail++; $display("FAIL rst_outputs got we=%b addr=%h din=%h done=%b want all 0", we1, addr1, din1, done1);
      end
      tick();
      n_checks++; if (mem1[1] !== 64'h2020_2020_2020_2020) begin
         n_fail++; $display("FAIL rst_suppress got %h want 2020202020202020", mem1[1]);
      end
      n_checks++; if (wr_cnt1 - w0 !== 1) begin n_fail++; $display("FAIL rst_writes got %0d want 1", wr_cnt1 - w0); end
      rst1 = 1'b0;
      run1(cyc);
      n_checks++; if (cyc !== 1537) begin n_fail++; $display("FAIL rerun_done_cycle got %0d want 1537", cyc); end
      n_checks++; if (mem1[0] !== 64'h0101_0101_0101_0101) begin
         n_fail++; $display("FAIL rerun_word0 got %h want 0101010101010101", mem1[0]);
      end
      n_checks++; if (mem1[1] !== 64'h0404_0404_0404_0404) begin
         n_fail++; $display("FAIL rerun_word1 got %h want 0404040404040404", mem1[1]);
      end
      n_checks++; if (mem1[511] !== 64'h0404_0404_0404_0404) begin
         n_fail++; $display("FAIL rerun_word511 got %h want 0404040404040404", mem1[511]);
      end
      start1 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_neg_one();
      test_sat_window();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
